// File: rtl/uart_link_if.sv
// Signal bundle between the miner-link sequencer and the surrounding UART/hash logic.
// The controller takes the slave view; whatever feeds it takes the master view.
interface uart_link_if;
    logic        rxce;
    logic        is_receiving;
    logic        is_transmitting;
    logic [31:0] nonce_in;
    logic        nonce_valid;
    logic        txce;
    logic [7:0]  tx;
    logic        nonce_busy;
    logic        nonce_done;
    logic        nonce_drop;
    logic        tx_error;
    logic [6:0]  header_count;
    logic        header_valid;
    logic        rx_timeout;

    modport master (
        output rxce, is_receiving, is_transmitting, nonce_in, nonce_valid,
        input  txce, tx, nonce_busy, nonce_done, nonce_drop, tx_error,
               header_count, header_valid, rx_timeout
    );

    modport slave (
        input  rxce, is_receiving, is_transmitting, nonce_in, nonce_valid,
        output txce, tx, nonce_busy, nonce_done, nonce_drop, tx_error,
               header_count, header_valid, rx_timeout
    );
endinterface

// File: rtl/uart_link_ctrl.sv
// Miner UART link sequencer: frames received bytes into block headers with an
// inter-byte timeout, and reports found nonces MSB-first through txce/tx.
module uart_link_ctrl #(
    parameter int HEADER_BYTES = 80,
    parameter int TX_BYTES     = 4,
    parameter int RX_TIMEOUT   = 500000,
    parameter int ACK_WAIT     = 16
) (
    input  logic      clock,
    input  logic      reset,
    uart_link_if.slave link
);
    localparam int IDX_W = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
    localparam int ACK_W = $clog2(ACK_WAIT + 1);
    localparam int TMR_W = $clog2(RX_TIMEOUT + 1);
    localparam int HC_W  = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_STROBE,
        ST_ACK,
        ST_DRAIN
    } tx_state_t;

    tx_state_t        r_state;
    tx_state_t        w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [31:0]      r_nonce;
    logic [7:0]       r_tx;
    logic [7:0]       w_tx_byte;
    logic             r_txce;
    logic             r_nonce_done;
    logic             r_nonce_drop;
    logic             r_tx_error;
    logic [ACK_W-1:0] r_ack_timer;
    logic             w_capture;
    logic             w_done;
    logic             w_error;

    logic [7:0] w_in_bytes   [TX_BYTES];
    logic [7:0] w_held_bytes [TX_BYTES];

    logic [HC_W-1:0]  r_header_count;
    logic [TMR_W-1:0] r_idle_timer;
    logic             r_header_valid;
    logic             r_rx_timeout;
    logic             w_rx_last;
    logic             w_rx_expire;

    genvar gi;
    generate
        for (gi = 0; gi < TX_BYTES; gi++) begin : g_bytes
            assign w_in_bytes[gi]   = link.nonce_in[8*gi +: 8];
            assign w_held_bytes[gi] = r_nonce[8*gi +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // TX sequencer: next state and byte selection
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        w_error      = 1'b0;
        w_tx_byte    = 8'h00;

        case (r_state)
            ST_IDLE: begin
                if (link.nonce_valid) begin
                    w_capture    = 1'b1;
                    w_idx_next   = IDX_W'(TX_BYTES - 1);
                    w_state_next = link.is_receiving ? ST_PEND : ST_STROBE;
                end
            end
            ST_PEND: begin
                if (!link.is_receiving) begin
                    w_state_next = ST_STROBE;
                end
            end
            ST_STROBE: begin
                w_state_next = ST_ACK;
            end
            ST_ACK: begin
                // The ack timer starts in STROBE, so the abort lands ACK_WAIT clocks after txce.
                if (link.is_transmitting) begin
                    w_state_next = ST_DRAIN;
                end else if (r_ack_timer == ACK_W'(ACK_WAIT - 1)) begin
                    w_error      = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!link.is_transmitting) begin
                    if (r_idx == '0) begin
                        w_done       = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_idx_next   = r_idx - IDX_W'(1);
                        w_state_next = link.is_receiving ? ST_PEND : ST_STROBE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // On capture the nonce register is not loaded yet, so take the byte from the input.
        if (w_capture) begin
            w_tx_byte = w_in_bytes[w_idx_next];
        end else begin
            w_tx_byte = w_held_bytes[w_idx_next];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_nonce      <= '0;
            r_tx         <= '0;
            r_txce       <= 1'b0;
            r_nonce_done <= 1'b0;
            r_nonce_drop <= 1'b0;
            r_tx_error   <= 1'b0;
            r_ack_timer  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_txce       <= (w_state_next == ST_STROBE);
            r_nonce_done <= w_done;
            r_tx_error   <= w_error;
            r_nonce_drop <= link.nonce_valid && (r_state != ST_IDLE);
            if (w_capture) begin
                r_nonce <= link.nonce_in;
            end
            if (w_state_next == ST_STROBE) begin
                r_tx <= w_tx_byte;
            end
            if ((r_state == ST_STROBE) || (r_state == ST_ACK)) begin
                r_ack_timer <= r_ack_timer + ACK_W'(1);
            end else begin
                r_ack_timer <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX framing and inter-byte timeout
    // ------------------------------------------------------------------
    assign w_rx_last   = (r_header_count == HC_W'(HEADER_BYTES - 1));
    // A byte arriving on the expiry clock takes priority over the timeout.
    assign w_rx_expire = (r_header_count != '0) && !link.rxce &&
                         (r_idle_timer == TMR_W'(RX_TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_header_count <= '0;
            r_idle_timer   <= '0;
            r_header_valid <= 1'b0;
            r_rx_timeout   <= 1'b0;
        end else begin
            r_header_valid <= link.rxce && w_rx_last;
            r_rx_timeout   <= w_rx_expire;
            if (link.rxce) begin
                r_header_count <= w_rx_last ? '0 : r_header_count + HC_W'(1);
                r_idle_timer   <= '0;
            end else if (w_rx_expire) begin
                r_header_count <= '0;
                r_idle_timer   <= '0;
            end else if (r_header_count != '0) begin
                r_idle_timer <= r_idle_timer + TMR_W'(1);
            end else begin
                r_idle_timer <= '0;
            end
        end
    end

    assign link.txce         = r_txce;
    assign link.tx           = r_tx;
    assign link.nonce_busy   = (r_state != ST_IDLE);
    assign link.nonce_done   = r_nonce_done;
    assign link.nonce_drop   = r_nonce_drop;
    assign link.tx_error     = r_tx_error;
    assign link.header_count = r_header_count;
    assign link.header_valid = r_header_valid;
    assign link.rx_timeout   = r_rx_timeout;
endmodule

// File: tb/tb_uart_link_ctrl.sv
// Scoreboard bench for uart_link_ctrl: stimulus pushes expected bytes/events,
// a negedge monitor pops and compares whenever the controller emits something.
module tb_uart_link_ctrl;
    localparam int HB  = 80;
    localparam int TXB = 4;
    localparam int RXT = 300;
    localparam int AW  = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    uart_link_if link();

    uart_link_ctrl #(
        .HEADER_BYTES(HB),
        .TX_BYTES    (TXB),
        .RX_TIMEOUT  (RXT),
        .ACK_WAIT    (AW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .link (link)
    );

    typedef struct {
        logic [7:0] b;
        int         cyc;
    } tx_exp_t;

    typedef struct {
        bit is_err;
        int cyc;
    } end_exp_t;

    tx_exp_t  exp_tx[$];
    end_exp_t exp_end[$];
    int       exp_drop[$];
    int       exp_hv[$];
    int       exp_to[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int txce_seen = 0;
    int ends_seen = 0;
    bit ack_en = 1'b1;
    int model_cnt = 0;
    int model_idle = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_pending(input string name, input int depth);
        checks++;
        if (depth == 0) begin
            errors++;
            $display("FAIL %s cycle %0d: pulse seen with nothing expected", name, cyc);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Reference framing model: bytes per frame and idle clocks since the last byte.
    initial begin
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
            if (reset) begin
                model_cnt  = 0;
                model_idle = 0;
            end else if (link.rxce) begin
                model_idle = 0;
                model_cnt  = model_cnt + 1;
                if (model_cnt == HB) begin
                    exp_hv.push_back(cyc);
                    model_cnt = 0;
                end
            end else if (model_cnt != 0) begin
                model_idle = model_idle + 1;
                if (model_idle == RXT) begin
                    exp_to.push_back(cyc);
                    model_cnt  = 0;
                    model_idle = 0;
                end
            end
        end
    end

    // UART model: goes busy 3 clocks after txce and stays busy for 10 clocks.
    initial begin
        link.is_transmitting = 1'b0;
        forever begin
            @(negedge clock);
            if (link.txce && ack_en) begin
                repeat (3) @(posedge clock);
                #1 link.is_transmitting = 1'b1;
                repeat (10) @(posedge clock);
                #1 link.is_transmitting = 1'b0;
            end
        end
    end

    // Monitor
    tx_exp_t  mon_t;
    end_exp_t mon_d;
    int       mon_c;
    initial begin
        forever begin
            @(negedge clock);
            if (cyc >= 1) begin
                chk("header_count", 32'(link.header_count), 32'(model_cnt));
                if (link.txce) begin
                    txce_seen++;
                    chk_pending("txce_unexpected", exp_tx.size());
                    if (exp_tx.size() != 0) begin
                        mon_t = exp_tx.pop_front();
                        chk("tx_byte", 32'(link.tx), 32'(mon_t.b));
                        if (mon_t.cyc >= 0) chk("txce_cycle", cyc, mon_t.cyc);
                    end
                end
                if (link.nonce_done || link.tx_error) begin
                    ends_seen++;
                    chk_pending("end_unexpected", exp_end.size());
                    if (exp_end.size() != 0) begin
                        mon_d = exp_end.pop_front();
                        chk("end_is_error", 32'(link.tx_error), 32'(mon_d.is_err));
                        chk("end_not_both", 32'(link.nonce_done & link.tx_error), 0);
                        if (mon_d.cyc >= 0) chk("end_cycle", cyc, mon_d.cyc);
                    end
                end
                if (link.nonce_drop) begin
                    chk_pending("drop_unexpected", exp_drop.size());
                    if (exp_drop.size() != 0) begin
                        mon_c = exp_drop.pop_front();
                        chk("drop_cycle", cyc, mon_c);
                    end
                end
                if (link.header_valid) begin
                    chk_pending("hv_unexpected", exp_hv.size());
                    if (exp_hv.size() != 0) begin
                        mon_c = exp_hv.pop_front();
                        chk("hv_cycle", cyc, mon_c);
                    end
                end
                if (link.rx_timeout) begin
                    chk_pending("to_unexpected", exp_to.size());
                    if (exp_to.size() != 0) begin
                        mon_c = exp_to.pop_front();
                        chk("to_cycle", cyc, mon_c);
                    end
                end
            end
        end
    end

    task automatic send_nonce(input logic [31:0] n, input int hold);
        tx_exp_t  e;
        end_exp_t d;
        for (int i = TXB - 1; i >= 0; i--) begin
            e.b   = n[8*i +: 8];
            e.cyc = (i == TXB - 1) ? (cyc + hold + 1) : -1;
            exp_tx.push_back(e);
        end
        d.is_err = 1'b0;
        d.cyc    = -1;
        exp_end.push_back(d);
        link.nonce_in     = n;
        link.nonce_valid  = 1'b1;
        link.is_receiving = (hold > 0);
        step(1);
        link.nonce_valid = 1'b0;
        if (hold > 0) begin
            step(hold - 1);
            link.is_receiving = 1'b0;
        end
    endtask

    task automatic wait_end(input string name);
        int start = ends_seen;
        int k = 0;
        while (ends_seen == start && k < 400) begin
            step(1);
            k++;
        end
        chk(name, ends_seen - start, 1);
        step(2);
        chk("busy_after_end", 32'(link.nonce_busy), 0);
    endtask

    task automatic rx_byte();
        link.rxce = 1'b1;
        step(1);
        link.rxce = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_txce"}, 32'(link.txce), 0);
        chk({name, "_tx"}, 32'(link.tx), 0);
        chk({name, "_busy"}, 32'(link.nonce_busy), 0);
        chk({name, "_done"}, 32'(link.nonce_done), 0);
        chk({name, "_drop"}, 32'(link.nonce_drop), 0);
        chk({name, "_err"}, 32'(link.tx_error), 0);
        chk({name, "_hcount"}, 32'(link.header_count), 0);
        chk({name, "_hvalid"}, 32'(link.header_valid), 0);
        chk({name, "_rxto"}, 32'(link.rx_timeout), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    tx_exp_t     te;
    end_exp_t    de;
    logic [31:0] nv;
    int          c0;
    int          t0;
    int          k;

    initial begin
        link.rxce         = 1'b0;
        link.is_receiving = 1'b0;
        link.nonce_in     = '0;
        link.nonce_valid  = 1'b0;
        reset             = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        step(2);

        // T1: fixed nonce through an ideal UART, with a dropped request mid-report
        c0 = cyc;
        send_nonce(32'h12345678, 0);
        step(19);
        exp_drop.push_back(cyc + 1);
        link.nonce_in    = $urandom;
        link.nonce_valid = 1'b1;
        step(1);
        link.nonce_valid = 1'b0;
        wait_end("t1_report_end");
        $display("T1 nonce 12345678 issued at cycle %0d", c0);

        // T2: full 80-byte header, 20 clocks apart
        for (int i = 0; i < HB - 1; i++) begin
            rx_byte();
            step(19);
        end
        chk("t2_count_79", 32'(link.header_count), 79);
        rx_byte();
        chk("t2_hvalid", 32'(link.header_valid), 1);
        chk("t2_count_wrap", 32'(link.header_count), 0);
        step(5);
        $display("T2 header frame of %0d bytes", HB);

        // T3: partial frame timeout, then the expiry-clock collision and one clock past it
        for (int i = 0; i < 10; i++) begin
            rx_byte();
            step(4);
        end
        step(RXT + 5);
        chk("t3_count_after_to", 32'(link.header_count), 0);
        rx_byte();
        step(RXT - 1);
        rx_byte();
        chk("t3_collision_counts", 32'(link.header_count), 2);
        step(RXT);
        rx_byte();
        chk("t3_late_byte_new_frame", 32'(link.header_count), 1);
        step(RXT + 5);
        chk("t3_final_count", 32'(link.header_count), 0);
        $display("T3 timeout and boundary bytes done at cycle %0d", cyc);

        // T4: request while the receiver is busy
        nv = {8'h12, 24'($urandom)};
        send_nonce(nv, 6);
        wait_end("t4_report_end");
        $display("T4 nonce %08h held off 6 cycles", nv);

        // T5: no ack from the UART, second request dropped
        ack_en = 1'b0;
        c0 = cyc;
        nv = $urandom;
        te.b = nv[31:24];
        te.cyc = c0 + 1;
        exp_tx.push_back(te);
        de.is_err = 1'b1;
        de.cyc = c0 + 1 + AW;
        exp_end.push_back(de);
        link.nonce_in    = nv;
        link.nonce_valid = 1'b1;
        step(1);
        link.nonce_valid = 1'b0;
        step(3);
        exp_drop.push_back(cyc + 1);
        link.nonce_in    = ~nv;
        link.nonce_valid = 1'b1;
        step(1);
        link.nonce_valid = 1'b0;
        wait_end("t5_error_end");
        ack_en = 1'b1;
        $display("T5 nonce %08h aborted without ack", nv);

        // T6: reset during the second byte's drain
        nv = $urandom;
        for (int i = TXB - 1; i >= TXB - 2; i--) begin
            te.b = nv[8*i +: 8];
            te.cyc = -1;
            exp_tx.push_back(te);
        end
        t0 = txce_seen;
        link.nonce_in    = nv;
        link.nonce_valid = 1'b1;
        step(1);
        link.nonce_valid = 1'b0;
        k = 0;
        while (txce_seen < t0 + 2 && k < 200) begin
            step(1);
            k++;
        end
        chk("t6_two_bytes", txce_seen - t0, 2);
        step(8);
        chk("t6_busy_in_drain", 32'(link.nonce_busy), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_all_zero("t6_reset");
        step(30);
        nv = $urandom;
        send_nonce(nv, 0);
        wait_end("t6_restart_end");
        $display("T6 restart with nonce %08h", nv);

        // Random: concurrent reports and header frame
        fork
            begin
                for (int r = 0; r < 6; r++) begin
                    send_nonce($urandom, int'($urandom_range(0, 4)));
                    wait_end("rand_report_end");
                    step(int'($urandom_range(0, 7)));
                end
            end
            begin
                for (int i = 0; i < HB + 7; i++) begin
                    rx_byte();
                    step(int'($urandom_range(1, 30)));
                end
            end
        join
        step(RXT + 20);
        $display("RAND phase done at cycle %0d", cyc);

        chk("left_tx", exp_tx.size(), 0);
        chk("left_end", exp_end.size(), 0);
        chk("left_drop", exp_drop.size(), 0);
        chk("left_hv", exp_hv.size(), 0);
        chk("left_to", exp_to.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
